alt_vip_common_control_packet_decoder: RTL and testbench

Avalon-ST VIP sink-side decoder, the receive counterpart of the control packet encoder. It sits between an external VIP stream and a user algorithm. It parses control packets (type 4'hF) into width, height and interlaced registers, strips the header beat from video packets (type 4'h0), and forwards pixel data. All other packet types are silently discarded.

---
 rtl/alt_vip_common_pkg.sv | 15 +
 rtl/alt_vip_common_ctrl_nibble_collector.sv | 51 +++++
 rtl/alt_vip_common_control_packet_decoder.sv | 125 ++++++++++++
 tb/tb_alt_vip_common_control_packet_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vip_common_pkg.sv
// Shared VIP stream definitions: packet type codes, control-packet length and decoder states.
package alt_vip_common_pkg;

  localparam logic [3:0] VIP_PKT_CTRL  = 4'hF;
  localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;
  localparam int         CTRL_NIBBLES  = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CTRL    = 2'd1,
    VIDEO   = 2'd2,
    DISCARD = 2'd3
  } dec_state_e;

endpackage

// File: rtl/alt_vip_common_ctrl_nibble_collector.sv
// Gathers the nine control-packet nibbles (w3..w0, h3..h0, int) from successive beats;
// nibble k lives at nibbles_next[k*4 +: 4]. Outputs are the post-beat view so eop can commit in the same cycle.
module alt_vip_common_ctrl_nibble_collector
  import alt_vip_common_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clear,
  input  logic                                    beat_en,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] beat_data,
  output logic [CTRL_NIBBLES*4-1:0]               nibbles_next,
  output logic                                    complete_next
);

  localparam int CW = 4;

  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_n;
  logic [CTRL_NIBBLES*4-1:0] nib_q;

  always_comb begin
    nibbles_next = nib_q;
    cnt_n        = cnt_q;
    if (beat_en) begin
      // Symbols past the ninth nibble are ignored.
      for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
        if (int'(cnt_q) + s < CTRL_NIBBLES)
          nibbles_next[(int'(cnt_q) + s)*4 +: 4] = beat_data[s*BITS_PER_SYMBOL +: 4];
      end
      if (int'(cnt_q) + SYMBOLS_PER_BEAT >= CTRL_NIBBLES)
        cnt_n = CW'(CTRL_NIBBLES);
      else
        cnt_n = cnt_q + CW'(SYMBOLS_PER_BEAT);
    end
    complete_next = (cnt_n == CW'(CTRL_NIBBLES));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      nib_q <= '0;
    end else if (beat_en) begin
      cnt_q <= cnt_n;
      nib_q <= nibbles_next;
    end
  end

endmodule

// File: rtl/alt_vip_common_control_packet_decoder.sv
// VIP sink-side decoder: latches control packets, forwards video pixels without the header beat.
// Optional VIP_DEC_FRAME_COUNT_EN adds a frame_count output counting completed video packets.
module alt_vip_common_control_packet_decoder
  import alt_vip_common_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic                                        din_ready,
  input  logic                                        din_valid,
  input  logic                                        din_sop,
  input  logic                                        din_eop,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic [15:0]                                 width,
  output logic [15:0]                                 height,
  output logic [3:0]                                  interlaced,
  output logic                                        vip_ctrl_valid,
  output logic                                        vip_ctrl_error,
`ifdef VIP_DEC_FRAME_COUNT_EN
  output logic [15:0]                                 frame_count,
`endif
  output dec_state_e                                  dbg_state
);

  // Handshake: a beat moves on a side when valid & ready are both high in the same cycle;
  // valid never waits on ready, and data/sop/eop are only meaningful while valid is high.

  dec_state_e                state_q, state_n;
  logic                      first_q;
  logic                      xfer, hdr, ctrl_beat;
  logic [3:0]                pkt_type;
  logic [CTRL_NIBBLES*4-1:0] nib_next;
  logic                      complete_next;

  assign xfer      = din_valid & din_ready;
  assign hdr       = xfer & din_sop;
  assign pkt_type  = din_data[3:0];
  assign ctrl_beat = xfer & ~din_sop & (state_q == CTRL);
  assign dbg_state = state_q;

  alt_vip_common_ctrl_nibble_collector #(
    .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
    .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT)
  ) u_collector (
    .clk          (clk),
    .rst          (rst),
    .clear        (hdr),
    .beat_en      (ctrl_beat),
    .beat_data    (din_data),
    .nibbles_next (nib_next),
    .complete_next(complete_next)
  );

  always_comb begin
    state_n    = state_q;
    din_ready  = ~rst;
    dout_valid = 1'b0;
    if (state_q == VIDEO) begin
      // A sop beat in VIDEO is a new header, so it is never presented as a pixel.
      din_ready  = ~rst & dout_ready;
      dout_valid = ~rst & din_valid & ~din_sop;
    end
    dout_sop  = dout_valid & first_q;
    dout_eop  = dout_valid & din_eop;
    dout_data = din_data;

    if (hdr) begin
      if (din_eop)                      state_n = IDLE;
      else if (pkt_type == VIP_PKT_CTRL)  state_n = CTRL;
      else if (pkt_type == VIP_PKT_VIDEO) state_n = VIDEO;
      else                              state_n = DISCARD;
    end else if (xfer && din_eop) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      first_q        <= 1'b1;
      width          <= '0;
      height         <= '0;
      interlaced     <= '0;
      vip_ctrl_valid <= 1'b0;
      vip_ctrl_error <= 1'b0;
    end else begin
      state_q        <= state_n;
      vip_ctrl_valid <= 1'b0;
      vip_ctrl_error <= 1'b0;
      if (hdr && state_q == CTRL) begin
        vip_ctrl_error <= 1'b1;
      end else if (ctrl_beat && din_eop) begin
        if (complete_next) begin
          width          <= {nib_next[3:0], nib_next[7:4], nib_next[11:8], nib_next[15:12]};
          height         <= {nib_next[19:16], nib_next[23:20], nib_next[27:24], nib_next[31:28]};
          interlaced     <= nib_next[35:32];
          vip_ctrl_valid <= 1'b1;
        end else begin
          vip_ctrl_error <= 1'b1;
        end
      end
      if (hdr)
        first_q <= 1'b1;
      else if (xfer && state_q == VIDEO)
        first_q <= din_eop;
    end
  end

`ifdef VIP_DEC_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      frame_count <= '0;
    else if (xfer && state_q == VIDEO && !din_sop && din_eop)
      frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alt_vip_common_control_packet_decoder.sv
// Directed bench for the control packet decoder: control decode, video pass-through, truncation and abandonment.
module tb_alt_vip_common_control_packet_decoder;
  import alt_vip_common_pkg::*;

  localparam int DW = 24;
  localparam int W  = DW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_ready, din_valid, din_sop, din_eop;
  logic [DW-1:0] din_data;
  logic          dout_ready, dout_valid, dout_sop, dout_eop;
  logic [DW-1:0] dout_data;
  logic [15:0]   width, height;
  logic [3:0]    interlaced;
  logic          vip_ctrl_valid, vip_ctrl_error;
  dec_state_e    dbg_state;
`ifdef VIP_DEC_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  alt_vip_common_control_packet_decoder #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din_ready     (din_ready),
    .din_valid     (din_valid),
    .din_sop       (din_sop),
    .din_eop       (din_eop),
    .din_data      (din_data),
    .dout_ready    (dout_ready),
    .dout_valid    (dout_valid),
    .dout_sop      (dout_sop),
    .dout_eop      (dout_eop),
    .dout_data     (dout_data),
    .width         (width),
    .height        (height),
    .interlaced    (interlaced),
    .vip_ctrl_valid(vip_ctrl_valid),
    .vip_ctrl_error(vip_ctrl_error),
`ifdef VIP_DEC_FRAME_COUNT_EN
    .frame_count   (frame_count),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int vcnt = 0, ecnt = 0, both_cnt = 0;
  int mirror_bad = 0, not_ready = 0;
  bit toggle_en = 1'b0;
  int rdy_idx = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  always @(negedge clk) begin
    if (vip_ctrl_valid) vcnt++;
    if (vip_ctrl_error) ecnt++;
    if (vip_ctrl_valid && vip_ctrl_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic apply_ready();
    if (toggle_en) begin
      dout_ready = (rdy_idx % 2 == 0);
      rdy_idx++;
    end
  endtask

  task automatic sample_out();
    if (dbg_state == VIDEO && din_ready !== dout_ready) mirror_bad++;
    if (dout_valid && dout_ready) obs_q.push_back({dout_sop, dout_eop, dout_data});
  endtask

  // driver: holds one beat until the DUT accepts it
  task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d);
    int guard = 0;
    din_valid = 1'b1;
    din_sop   = sop;
    din_eop   = eop;
    din_data  = d;
    apply_ready();
    #1;
    while (!din_ready && guard < 20) begin
      not_ready++;
      sample_out();
      @(posedge clk);
      @(negedge clk);
      apply_ready();
      #1;
      guard++;
    end
    if (guard >= 20) check("beat_accept_timeout", 32'd1, 32'd0);
    sample_out();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clear_counts();
    vcnt = 0;
    ecnt = 0;
    not_ready = 0;
    mirror_bad = 0;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic video_abcd();
    send(1'b1, 1'b0, 24'h000000);
    send(1'b0, 1'b0, 24'hAAAAAA);
    send(1'b0, 1'b0, 24'hBBBBBB);
    send(1'b0, 1'b0, 24'hCCCCCC);
    send(1'b0, 1'b1, 24'hDDDDDD);
    exp_q.push_back({2'b10, 24'hAAAAAA});
    exp_q.push_back({2'b00, 24'hBBBBBB});
    exp_q.push_back({2'b00, 24'hCCCCCC});
    exp_q.push_back({2'b01, 24'hDDDDDD});
  endtask

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_sop    = 1'b0;
    din_eop    = 1'b0;
    din_data   = '0;
    dout_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("din_ready_in_reset", din_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_width", width, 16'h0);
    check("rst_height", height, 16'h0);
    check("rst_interlaced", interlaced, 4'h0);
    check("rst_pulses", {vip_ctrl_valid, vip_ctrl_error}, 2'b00);
    check("rst_state", dbg_state, IDLE);
    check("rst_din_ready", din_ready, 1'b1);
    check("rst_dout_valid", dout_valid, 1'b0);

    // 640x480 control packet
    idle(1);
    clear_counts();
    send(1'b1, 1'b0, 24'h00000F);
    send(1'b0, 1'b0, 24'h080200);
    send(1'b0, 1'b0, 24'h010000);
    send(1'b0, 1'b1, 24'h03000E);
    idle(2);
    check("ctrl_width", width, 16'h0280);
    check("ctrl_height", height, 16'h01E0);
    check("ctrl_interlaced", interlaced, 4'h3);
    check("ctrl_valid_pulses", vcnt, 1);
    check("ctrl_error_pulses", ecnt, 0);

    // video with dout_ready held high
    video_abcd();
    idle(2);
    compare_stream("video_ready_high");

    // video with dout_ready toggling 1,0,1,0
    clear_counts();
    toggle_en = 1'b1;
    rdy_idx = 0;
    video_abcd();
    toggle_en = 1'b0;
    dout_ready = 1'b1;
    idle(2);
    compare_stream("video_ready_toggle");
    check("din_ready_mirror", mirror_bad, 0);
    check("toggle_stalled", not_ready > 0, 1'b1);

    // truncated control packet (6 nibbles)
    clear_counts();
    send(1'b1, 1'b0, 24'h00000F);
    send(1'b0, 1'b0, 24'h030201);
    send(1'b0, 1'b1, 24'h060504);
    idle(2);
    check("trunc_error_pulses", ecnt, 1);
    check("trunc_valid_pulses", vcnt, 0);
    check("trunc_width_kept", width, 16'h0280);
    check("trunc_height_kept", height, 16'h01E0);
    check("trunc_int_kept", interlaced, 4'h3);

    // following control packet decodes normally
    clear_counts();
    send(1'b1, 1'b0, 24'h00000F);
    send(1'b0, 1'b0, 24'h030201);
    send(1'b0, 1'b0, 24'h060504);
    send(1'b0, 1'b1, 24'h090807);
    idle(2);
    check("ctrl2_width", width, 16'h1234);
    check("ctrl2_height", height, 16'h5678);
    check("ctrl2_interlaced", interlaced, 4'h9);
    check("ctrl2_pulses", {vcnt[7:0], ecnt[7:0]}, {8'd1, 8'd0});

    // type 5 packet of 10 beats is discarded
    clear_counts();
    send(1'b1, 1'b0, 24'h000005);
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 24'(i * 24'h010101));
    send(1'b0, 1'b1, 24'h777777);
    idle(2);
    check("discard_not_ready", not_ready, 0);
    check("discard_no_output", obs_q.size(), 0);
    check("discard_no_pulses", {vcnt[7:0], ecnt[7:0]}, 16'h0);

    // new sop mid-CTRL abandons it, then the new packet decodes
    clear_counts();
    send(1'b1, 1'b0, 24'h00000F);
    send(1'b0, 1'b0, 24'h030201);
    send(1'b1, 1'b0, 24'h00000F);
    send(1'b0, 1'b0, 24'h0C0B0A);
    send(1'b0, 1'b0, 24'h01000D);
    send(1'b0, 1'b1, 24'h020302);
    idle(2);
    check("abandon_ctrl_error", ecnt, 1);
    check("abandon_ctrl_valid", vcnt, 1);
    check("abandon_ctrl_width", width, 16'hABCD);
    check("abandon_ctrl_height", height, 16'h0123);
    check("abandon_ctrl_int", interlaced, 4'h2);

    // new sop mid-VIDEO: no eop on the abandoned frame, next frame gets sop
    send(1'b1, 1'b0, 24'h000000);
    send(1'b0, 1'b0, 24'hEEEEEE);
    send(1'b0, 1'b0, 24'hFFFFFF);
    send(1'b1, 1'b0, 24'h000000);
    send(1'b0, 1'b1, 24'h123456);
    idle(2);
    exp_q.push_back({2'b10, 24'hEEEEEE});
    exp_q.push_back({2'b00, 24'hFFFFFF});
    exp_q.push_back({2'b11, 24'h123456});
    compare_stream("abandon_video");
`ifdef VIP_DEC_FRAME_COUNT_EN
    check("frame_count_three", frame_count, 16'd3);
`endif

    // reset mid-frame drops the partial packet
    send(1'b1, 1'b0, 24'h000000);
    send(1'b0, 1'b0, 24'h654321);
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_state", dbg_state, IDLE);
`ifdef VIP_DEC_FRAME_COUNT_EN
    check("midrst_frame_count", frame_count, 16'd0);
`endif
    send(1'b0, 1'b1, 24'h999999);
    idle(2);
    exp_q.push_back({2'b10, 24'h654321});
    compare_stream("midrst_stream");
    check("never_both_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
